truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer_pkg.sv | 18 +
 rtl/truth_table_sequencer_if.sv | 35 +++
 rtl/truth_table_sequencer_settle_counter.sv | 41 ++++
 rtl/truth_table_sequencer.sv | 124 ++++++++++++
 tb/tb_truth_table_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer: FSM encoding,
// vector count/index width and the settle counter width.
package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int N_VECTORS = 8;
    localparam int INDEX_W   = 3;
    localparam int CNT_W     = 4;

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(N_VECTORS - 1);

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Signal bundle between the sequencer (master) and the function under test
// plus the controlling agent (slave).
interface truth_table_sequencer_if;
    import truth_table_pkg::*;

    // Handshake: start is a level request sampled only in IDLE; done pulses for
    // one cycle when mismatch/error_count/pass are final, and those results hold
    // until the next accepted start. Keeping start high through a whole scan and
    // its DONE cycle chains the next scan with no idle gap.
    logic                 start;
    logic                 F;
    logic                 A;
    logic                 B;
    logic                 C;
    logic                 busy;
    logic                 done;
    logic [7:0]           mismatch;
    logic [3:0]           error_count;
    logic                 pass;
    state_t               dbg_state;
    logic [CNT_W-1:0]     dbg_settle;

    modport master (
        input  start, F,
        output A, B, C, busy, done, mismatch, error_count, pass,
               dbg_state, dbg_settle
    );

    modport slave (
        output start, F,
        input  A, B, C, busy, done, mismatch, error_count, pass,
               dbg_state, dbg_settle
    );

endinterface

// File: rtl/truth_table_sequencer_settle_counter.sv
// Counts how long the current vector has been driven; last flags the final
// settle cycle so the FSM can move to SAMPLE.
module settle_counter
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_VAL);

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks all 8 input vectors of a 3-input function, holds each for SETTLE_CYCLES,
// samples F and records per-vector mismatches against EXPECTED.
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter logic [7:0] EXPECTED      = 8'b0000_0000,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    truth_table_sequencer_if.master  bus
);

    state_t               state_q, state_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic [7:0]           mismatch_q, mismatch_d;
    logic [3:0]           err_q, err_d;
    logic                 pass_q, pass_d;
    logic                 hold_q, hold_d;

    logic                 settle_en;
    logic                 settle_clear;
    logic                 settle_last;
    logic [CNT_W-1:0]     settle_count;

    logic                 accept;
    logic                 miss_bit;
    logic [3:0]           err_next;
    logic                 busy_w;

    // Counter only runs while a vector settles; any other state parks it at 0.
    assign settle_en    = (state_q == ST_DRIVE);
    assign settle_clear = !settle_en;

    settle_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk   (clk),
        .reset (reset),
        .clear (settle_clear),
        .en    (settle_en),
        .count (settle_count),
        .last  (settle_last)
    );

    // In DONE, start only chains a new scan if it has stayed high since the
    // current scan was accepted; a fresh pulse landing on DONE is ignored.
    assign accept   = bus.start && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_DONE) && hold_q));
    assign miss_bit = (bus.F != EXPECTED[index_q]);
    assign err_next = err_q + {3'b000, miss_bit};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_DRIVE;
            ST_DRIVE:  if (settle_last) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (index_q == LAST_INDEX) ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_d = accept ? ST_DRIVE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        index_d    = index_q;
        mismatch_d = mismatch_q;
        err_d      = err_q;
        pass_d     = pass_q;
        hold_d     = hold_q && bus.start;
        if (accept) begin
            index_d    = '0;
            mismatch_d = '0;
            err_d      = '0;
            pass_d     = 1'b0;
            hold_d     = 1'b1;
        end else if (state_q == ST_SAMPLE) begin
            mismatch_d[index_q] = miss_bit;
            err_d               = err_next;
            if (index_q == LAST_INDEX) begin
                pass_d = (err_next == 4'd0);
            end else begin
                index_d = index_q + INDEX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_q    <= '0;
            mismatch_q <= '0;
            err_q      <= '0;
            pass_q     <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            index_q    <= index_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
            hold_q     <= hold_d;
        end
    end

    // Outputs come from registers only, so F never reaches them combinationally.
    always_comb begin
        busy_w = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
        bus.busy        = busy_w;
        bus.done        = (state_q == ST_DONE);
        {bus.A, bus.B, bus.C} = busy_w ? index_q : '0;
        bus.mismatch    = mismatch_q;
        bus.error_count = err_q;
        bus.pass        = pass_q;
        bus.dbg_state   = state_q;
        bus.dbg_settle  = settle_count;
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: three instances cover the
// EXPECTED/SETTLE_CYCLES combinations, results are checked against a model.
module tb_truth_table_sequencer;
    import truth_table_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0] start_v;
    logic       f_mode_a;

    truth_table_sequencer_if if_a ();
    truth_table_sequencer_if if_b ();
    truth_table_sequencer_if if_c ();

    assign if_a.start = start_v[0];
    assign if_b.start = start_v[1];
    assign if_c.start = start_v[2];
    assign if_a.F = f_mode_a & ~if_a.A & if_a.B & ~if_a.C;
    assign if_b.F = 1'b0;
    assign if_c.F = 1'b0;

    truth_table_sequencer #(.EXPECTED(8'b0000_0100), .SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.master));
    truth_table_sequencer #(.EXPECTED(8'hFF), .SETTLE_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.master));
    truth_table_sequencer #(.EXPECTED(8'b0000_0100), .SETTLE_CYCLES(1)) dut_c (
        .clk(clk), .reset(reset), .bus(if_c.master));

    logic [2:0] abc_w  [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic [7:0] mm_w   [3];
    logic [3:0] err_w  [3];
    logic       pass_w [3];

    assign abc_w[0] = {if_a.A, if_a.B, if_a.C};
    assign abc_w[1] = {if_b.A, if_b.B, if_b.C};
    assign abc_w[2] = {if_c.A, if_c.B, if_c.C};
    assign busy_w[0] = if_a.busy;  assign busy_w[1] = if_b.busy;  assign busy_w[2] = if_c.busy;
    assign done_w[0] = if_a.done;  assign done_w[1] = if_b.done;  assign done_w[2] = if_c.done;
    assign mm_w[0] = if_a.mismatch;  assign mm_w[1] = if_b.mismatch;  assign mm_w[2] = if_c.mismatch;
    assign err_w[0] = if_a.error_count;  assign err_w[1] = if_b.error_count;  assign err_w[2] = if_c.error_count;
    assign pass_w[0] = if_a.pass;  assign pass_w[1] = if_b.pass;  assign pass_w[2] = if_c.pass;

    // ---------------- scoreboard ----------------
    logic [12:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected {mismatch, error_count, pass}; f_fn selects F = ~A&B&~C, else F = 0.
    function automatic logic [12:0] model_scan(input logic [7:0] exp_tbl, input logic f_fn);
        logic [7:0] mm;
        logic [3:0] cnt;
        logic       f;
        mm  = '0;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            f     = f_fn && (i == 2);
            mm[i] = (f != exp_tbl[i]);
            cnt   = cnt + {3'b000, mm[i]};
        end
        return {mm, cnt, (cnt == 4'd0)};
    endfunction

    task automatic sb_compare(input int d, input string tag);
        logic [12:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {mm_w[d], err_w[d], pass_w[d]}, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_scan(input int d, input int settle, input logic [7:0] exp_tbl,
                            input logic f_fn, input bit repulse);
        int          scan_len;
        int          done_at;
        int          n_done;
        logic [12:0] e_model;
        scan_len = 8 * (settle + 1);
        done_at  = 0;
        n_done   = 0;
        e_model  = model_scan(exp_tbl, f_fn);
        exp_q.push_back(e_model);
        @(negedge clk);
        start_v[d] = 1'b1;
        for (int n = 1; n <= scan_len + 12; n++) begin
            @(negedge clk);
            if (n <= scan_len) begin
                check("abc", 32'(abc_w[d]), 32'((n - 1) / (settle + 1)));
                check("busy", 32'(busy_w[d]), 32'd1);
            end
            if (done_w[d]) begin
                n_done++;
                done_at = n;
                check("done_busy", 32'(busy_w[d]), 32'd0);
                check("done_abc", 32'(abc_w[d]), 32'd0);
                sb_compare(d, "results");
            end
            start_v[d] = repulse && (n == 5 || n == scan_len + 1);
        end
        check("done_cycle", done_at, scan_len + 1);
        check("done_count", n_done, 1);
        check("results_held", {mm_w[d], err_w[d], pass_w[d]}, e_model);
        check("idle_abc", 32'(abc_w[d]), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_abc"}, 32'(abc_w[0]), 32'd0);
        check({tag, "_busy"}, 32'(busy_w[0]), 32'd0);
        check({tag, "_done"}, 32'(done_w[0]), 32'd0);
        check({tag, "_mismatch"}, 32'(mm_w[0]), 32'd0);
        check({tag, "_errcnt"}, 32'(err_w[0]), 32'd0);
        check({tag, "_pass"}, 32'(pass_w[0]), 32'd0);
        check({tag, "_state"}, 32'(if_a.dbg_state), 32'(ST_IDLE));
    endtask

    task automatic reset_mid_scan();
        int n_done;
        f_mode_a = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        check("pre_reset_mismatch", 32'(mm_w[0]), 32'h04);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_w[0]) n_done++;
        end
        check("no_done_after_reset", n_done, 0);
        check_all_zero("after_reset");
    endtask

    task automatic held_start_scan();
        int d1;
        int d2;
        int n_done;
        d1 = 0;
        d2 = 0;
        n_done = 0;
        exp_q.push_back(model_scan(8'b0000_0100, 1'b0));
        exp_q.push_back(model_scan(8'b0000_0100, 1'b0));
        @(negedge clk);
        start_v[2] = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (done_w[2]) begin
                n_done++;
                if (n_done == 1) d1 = n;
                else d2 = n;
                sb_compare(2, "held_results");
            end
            if (n == 18) begin
                check("held_cleared_mismatch", 32'(mm_w[2]), 32'd0);
                check("held_cleared_errcnt", 32'(err_w[2]), 32'd0);
                check("held_rescan_busy", 32'(busy_w[2]), 32'd1);
                check("held_rescan_abc", 32'(abc_w[2]), 32'd0);
            end
            if (n == 20) start_v[2] = 1'b0;
        end
        check("held_done1_cycle", d1, 17);
        check("held_done2_cycle", d2, 34);
        check("held_done_count", n_done, 2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset    = 1'b1;
        start_v  = '0;
        f_mode_a = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        run_scan(0, 2, 8'b0000_0100, 1'b1, 1'b0);
        f_mode_a = 1'b0;
        run_scan(0, 2, 8'b0000_0100, 1'b0, 1'b0);
        run_scan(1, 2, 8'hFF, 1'b0, 1'b0);
        f_mode_a = 1'b1;
        run_scan(0, 2, 8'b0000_0100, 1'b1, 1'b1);
        reset_mid_scan();
        f_mode_a = 1'b1;
        run_scan(0, 2, 8'b0000_0100, 1'b1, 1'b0);
        held_start_scan();

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
